// File: rtl/rv_pkg.sv
// Shared RISC-V fetch definitions: opcodes the predecoder recognises and the
// 2-bit branch history counter encoding.
package rv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bht_ctr_e;

    localparam bht_ctr_e CTR_RESET = CTR_WNT;

endpackage

// File: rtl/rv_fetch_queue.sv
// Power-of-two FIFO between fetch and decode; flush empties it in one cycle,
// and a push is accepted when full if the head leaves in the same cycle.
module rv_fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    // Storage is never reset, so an empty queue must present zeros.
    assign head_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch: PC generation, single in-flight imem request, predecode
// with a bimodal BHT for conditional branches, and a decode-side fetch queue.
module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BHT_ENTRIES = 16,
    parameter int              FQ_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req_o,
    output logic [XLEN-1:0]           imem_addr_o,
    input  logic [31:0]               imem_instr_i,
    output logic                      id_valid_o,
    input  logic                      id_ready_i,
    output logic [31:0]               id_instr_o,
    output logic [XLEN-1:0]           id_pc_o,
    output logic                      id_pred_taken_o,
    input  logic                      ex_redirect_i,
    input  logic [XLEN-1:0]           ex_redirect_pc_i,
    input  logic                      ex_br_valid_i,
    input  logic [XLEN-1:0]           ex_br_pc_i,
    input  logic                      ex_br_taken_i,
    output logic [$clog2(FQ_DEPTH):0] fq_count_o
);

    localparam int IW = $clog2(BHT_ENTRIES);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int QW = 32 + XLEN + 1;

    function automatic bht_ctr_e ctr_next(input bht_ctr_e c, input logic taken);
        case (c)
            CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
            default: ctr_next = taken ? CTR_ST  : CTR_WT;
        endcase
    endfunction

    logic [XLEN-1:0]        pc_p0;
    logic [XLEN-1:0]        resp_pc_p1;
    logic                   resp_vld_p1;
    logic [CW-1:0]          fq_count;
    logic [CW:0]            occ;
    bht_ctr_e               bht [BHT_ENTRIES];
    logic [IW-1:0]          lk_idx;
    logic [IW-1:0]          up_idx;
    logic [6:0]             opc;
    logic                   is_br;
    logic                   is_jal;
    logic signed [12:0]     b_off;
    logic signed [20:0]     j_off;
    logic signed [XLEN-1:0] b_imm;
    logic signed [XLEN-1:0] j_imm;
    logic [XLEN-1:0]        pred_target;
    logic                   pred_taken;
    logic                   fq_push;
    logic [QW-1:0]          fq_head;
    logic                   unused_pc_bits;

    // p0: request stage
    assign occ         = {1'b0, fq_count} + (CW+1)'(resp_vld_p1);
    assign imem_req_o  = ~rst & ~ex_redirect_i & (occ < (CW+1)'(FQ_DEPTH));
    assign imem_addr_o = pc_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0       <= RESET_PC;
            resp_vld_p1 <= 1'b0;
        end else if (ex_redirect_i) begin
            pc_p0       <= ex_redirect_pc_i;
            resp_vld_p1 <= 1'b0;
        end else if (pred_taken) begin
            pc_p0       <= pred_target;
            resp_vld_p1 <= 1'b0;
        end else begin
            resp_vld_p1 <= imem_req_o;
            if (imem_req_o) pc_p0 <= pc_p0 + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req_o) resp_pc_p1 <= pc_p0;
    end

    // p1: response stage, predecode and BHT lookup
    assign opc    = imem_instr_i[6:0];
    assign is_br  = (opc == OPC_BRANCH);
    assign is_jal = (opc == OPC_JAL);
    assign b_off  = {imem_instr_i[31], imem_instr_i[7], imem_instr_i[30:25],
                     imem_instr_i[11:8], 1'b0};
    assign j_off  = {imem_instr_i[31], imem_instr_i[19:12], imem_instr_i[20],
                     imem_instr_i[30:21], 1'b0};
    assign b_imm  = XLEN'(b_off);
    assign j_imm  = XLEN'(j_off);

    assign lk_idx      = resp_pc_p1[IW+1:2];
    assign up_idx      = ex_br_pc_i[IW+1:2];
    assign pred_taken  = resp_vld_p1 & (is_jal | (is_br & (bht[lk_idx] >= CTR_WT)));
    assign pred_target = resp_pc_p1 + (is_jal ? $unsigned(j_imm) : $unsigned(b_imm));
    assign fq_push     = resp_vld_p1 & ~ex_redirect_i & ~rst;

    assign unused_pc_bits = ^{ex_br_pc_i[XLEN-1:IW+2], ex_br_pc_i[1:0]};

    // Lookup reads the registered array, so a same-cycle update is not visible yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RESET;
        end else if (ex_br_valid_i) begin
            bht[up_idx] <= ctr_next(bht[up_idx], ex_br_taken_i);
        end
    end

    // p2: fetch queue toward decode
    rv_fetch_queue #(
        .WIDTH (QW),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk       (clk),
        .rst       (rst),
        .flush     (ex_redirect_i),
        .push      (fq_push),
        .push_data ({imem_instr_i, resp_pc_p1, pred_taken}),
        .pop       (id_ready_i),
        .valid     (id_valid_o),
        .head_data (fq_head),
        .count     (fq_count)
    );

    assign {id_instr_o, id_pc_o, id_pred_taken_o} = fq_head;
    assign fq_count_o = fq_count;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: vector table for reset/stream/stall, plus
// sequences for prediction, redirect and branch-history training.
module tb_rv_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [63:0] id_pc_o;
    logic        id_pred_taken_o;
    logic        ex_redirect_i;
    logic [63:0] ex_redirect_pc_i;
    logic        ex_br_valid_i;
    logic [63:0] ex_br_pc_i;
    logic        ex_br_taken_i;
    logic [2:0]  fq_count_o;

    always #5 clk = ~clk;

    rv_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_instr_i     (imem_instr_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o),
        .id_pred_taken_o  (id_pred_taken_o),
        .ex_redirect_i    (ex_redirect_i),
        .ex_redirect_pc_i (ex_redirect_pc_i),
        .ex_br_valid_i    (ex_br_valid_i),
        .ex_br_pc_i       (ex_br_pc_i),
        .ex_br_taken_i    (ex_br_taken_i),
        .fq_count_o       (fq_count_o)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] sp_pc  [3];
    logic [31:0] sp_ins [3];
    int          sp_n = 0;
    logic [63:0] mem_a;

    // Program image: ADDI x1,x0,addr[11:0] everywhere except the special slots.
    function automatic logic [31:0] prog(input logic [63:0] a);
        logic [31:0] r;
        r = {a[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011};
        for (int i = 0; i < 3; i++)
            if (i < sp_n && sp_pc[i] == a) r = sp_ins[i];
        return r;
    endfunction

    // Instruction memory: address seen this cycle answers in the next.
    initial begin
        imem_instr_i = 32'h0;
        forever begin
            @(negedge clk);
            mem_a = imem_addr_o;
            @(posedge clk);
            #1;
            imem_instr_i = prog(mem_a);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_head(input string nm, input logic vld, input logic [63:0] pc,
                            input logic pred, input int cnt);
        chk({nm, ".valid"}, id_valid_o, vld);
        chk({nm, ".pc"}, id_pc_o, vld ? pc : 64'h0);
        chk({nm, ".instr"}, id_instr_o, vld ? prog(pc) : 32'h0);
        chk({nm, ".pred"}, id_pred_taken_o, vld ? pred : 1'b0);
        chk({nm, ".count"}, fq_count_o, cnt);
    endtask

    task automatic chk_req(input string nm, input logic req, input logic [63:0] addr);
        chk({nm, ".req"}, imem_req_o, req);
        chk({nm, ".addr"}, imem_addr_o, addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ex_redirect_i = 1'b0; ex_br_valid_i = 1'b0; id_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic train(input logic tk);
        @(negedge clk);
        ex_br_valid_i = 1'b1; ex_br_pc_i = 64'h48; ex_br_taken_i = tk;
        @(negedge clk);
        ex_br_valid_i = 1'b0;
    endtask

    task automatic observe(input string nm, input logic exp);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        ex_redirect_i = 1'b1; ex_redirect_pc_i = 64'h48; id_ready_i = 1'b1;
        @(negedge clk);
        ex_redirect_i = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (id_valid_o && id_pc_o == 64'h48) begin
                seen = 1'b1;
                chk(nm, id_pred_taken_o, exp);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no head at 0x48 within 8 cycles, got none, expected one", nm);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [63:0] addr;
        logic        vld;
        logic [63:0] pc;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rd, input logic rq, input logic [63:0] a,
                       input logic v, input logic [63:0] p, input int c);
        vec_t e;
        e.rst = r; e.rdy = rd; e.req = rq; e.addr = a; e.vld = v; e.pc = p; e.cnt = c;
        tbl.push_back(e);
    endtask

    typedef struct { logic tk; logic exp; } bht_t;
    bht_t btbl [9];

    initial begin
        rst = 1'b1; id_ready_i = 1'b1;
        ex_redirect_i = 1'b0; ex_redirect_pc_i = 64'h0;
        ex_br_valid_i = 1'b0; ex_br_pc_i = 64'h0; ex_br_taken_i = 1'b0;

        // reset, linear stream, stall to full, resume, reset mid-stream
        add(1, 1, 0, 64'd0,  0, 64'd0,  0);
        add(1, 1, 0, 64'd0,  0, 64'd0,  0);
        add(0, 1, 1, 64'd0,  0, 64'd0,  0);
        add(0, 1, 1, 64'd4,  0, 64'd0,  0);
        add(0, 1, 1, 64'd8,  1, 64'd0,  1);
        add(0, 1, 1, 64'd12, 1, 64'd4,  1);
        add(0, 0, 1, 64'd16, 1, 64'd8,  1);
        add(0, 0, 1, 64'd20, 1, 64'd8,  2);
        add(0, 0, 0, 64'd24, 1, 64'd8,  3);
        add(0, 0, 0, 64'd24, 1, 64'd8,  4);
        add(0, 0, 0, 64'd24, 1, 64'd8,  4);
        add(0, 1, 0, 64'd24, 1, 64'd8,  4);
        add(0, 1, 1, 64'd24, 1, 64'd12, 3);
        add(0, 1, 1, 64'd28, 1, 64'd16, 2);
        add(0, 1, 1, 64'd32, 1, 64'd20, 2);
        add(0, 1, 1, 64'd36, 1, 64'd24, 2);
        add(0, 1, 1, 64'd40, 1, 64'd28, 2);
        add(1, 1, 0, 64'd44, 1, 64'd32, 2);
        add(1, 1, 0, 64'd0,  0, 64'd0,  0);
        add(0, 1, 1, 64'd0,  0, 64'd0,  0);
        add(0, 1, 1, 64'd4,  0, 64'd0,  0);
        add(0, 1, 1, 64'd8,  1, 64'd0,  1);

        btbl[0] = '{1'b1, 1'b1}; btbl[1] = '{1'b1, 1'b1}; btbl[2] = '{1'b1, 1'b1};
        btbl[3] = '{1'b0, 1'b1}; btbl[4] = '{1'b0, 1'b0}; btbl[5] = '{1'b0, 1'b0};
        btbl[6] = '{1'b0, 1'b0}; btbl[7] = '{1'b1, 1'b0}; btbl[8] = '{1'b1, 1'b1};

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; id_ready_i = tbl[i].rdy;
            #1;
            chk_req($sformatf("v%0d", i), tbl[i].req, tbl[i].addr);
            chk_head($sformatf("v%0d", i), tbl[i].vld, tbl[i].pc, 1'b0, tbl[i].cnt);
        end

        // BEQ at 0x10 (+0x20) with counter trained to 11, JAL at 0x38 (-8)
        sp_n = 3;
        sp_pc[0] = 64'h10; sp_ins[0] = 32'h02000063;
        sp_pc[1] = 64'h38; sp_ins[1] = 32'hff9ff06f;
        sp_pc[2] = 64'h48; sp_ins[2] = 32'h02000063;
        do_reset();
        ex_br_valid_i = 1'b1; ex_br_pc_i = 64'h10; ex_br_taken_i = 1'b1;
        @(negedge clk);
        @(negedge clk); ex_br_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk); #1; chk_req("beq.n4", 1'b1, 64'h10);
        @(negedge clk); #1; chk_req("beq.n5", 1'b1, 64'h14);
        chk_head("beq.n5", 1'b1, 64'h0c, 1'b0, 1);
        @(negedge clk); #1; chk_req("beq.n6", 1'b1, 64'h30);
        chk_head("beq.n6", 1'b1, 64'h10, 1'b1, 1);
        @(negedge clk); #1; chk_req("beq.n7", 1'b1, 64'h34);
        chk_head("beq.n7", 1'b0, 64'h0, 1'b0, 0);
        @(negedge clk); #1; chk_head("beq.n8", 1'b1, 64'h30, 1'b0, 1);
        @(negedge clk); #1; chk_req("jal.n9", 1'b1, 64'h3c);
        @(negedge clk); #1; chk_req("jal.n10", 1'b1, 64'h30);
        chk_head("jal.n10", 1'b1, 64'h38, 1'b1, 1);
        @(negedge clk); #1; chk_head("jal.n11", 1'b0, 64'h0, 1'b0, 0);
        @(negedge clk); #1; chk_head("jal.n12", 1'b1, 64'h30, 1'b0, 1);

        // redirect to 0x100 with 3 queued entries and a response in flight
        do_reset();
        id_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1; chk_req("rdr.n3", 1'b1, 64'd12);
        @(negedge clk);
        ex_redirect_i = 1'b1; ex_redirect_pc_i = 64'h100;
        #1; chk("rdr.n4.req", imem_req_o, 1'b0);
        chk_head("rdr.n4", 1'b1, 64'h0, 1'b0, 3);
        @(negedge clk); ex_redirect_i = 1'b0;
        #1; chk_req("rdr.n5", 1'b1, 64'h100);
        chk_head("rdr.n5", 1'b0, 64'h0, 1'b0, 0);
        @(negedge clk); #1; chk_head("rdr.n6", 1'b0, 64'h0, 1'b0, 0);
        @(negedge clk); #1; chk_head("rdr.n7", 1'b1, 64'h100, 1'b0, 1);
        @(negedge clk); #1; chk_head("rdr.n8", 1'b1, 64'h100, 1'b0, 2);

        // counter training on one index, observed through the BEQ at 0x48
        do_reset();
        observe("bht.init", 1'b0);
        foreach (btbl[i]) begin
            train(btbl[i].tk);
            observe($sformatf("bht.step%0d", i), btbl[i].exp);
        end

        // lookup and update on the same index in the same cycle
        do_reset();
        @(negedge clk); ex_redirect_i = 1'b1; ex_redirect_pc_i = 64'h48;
        @(negedge clk); ex_redirect_i = 1'b0;
        #1; chk_req("same.req", 1'b1, 64'h48);
        @(negedge clk); ex_br_valid_i = 1'b1; ex_br_pc_i = 64'h48; ex_br_taken_i = 1'b1;
        @(negedge clk); ex_br_valid_i = 1'b0;
        #1; chk_head("same.head", 1'b1, 64'h48, 1'b0, 1);
        observe("same.later", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
